counter_display_core: RTL and testbench

//  Parametrised successor to the single-width counter/display path: N-digit hex or BCD
//  up/down counter with wrap or saturate, auto-tick or button stepping, and a multiplexed
//  7-segment scan driver. Single clock domain: all slow rates are clock enables, not

---
 rtl/counter_display_pkg.sv | 37 +++
 rtl/seg7_scan.sv | 59 +++++
 rtl/counter_display_core.sv | 116 +++++++++++
 tb/tb_counter_display_core.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_display_pkg.sv
// Shared encodings, glyph table and sizing helper for the counter/display path.
package counter_display_pkg;

   typedef enum logic [1:0] {
      MODE_AUTO  = 2'b00,
      MODE_BTN   = 2'b01,
      MODE_PAUSE = 2'b10
   } mode_e;

   // Active-low segments {g,f,e,d,c,b,a}, indexed by nibble value
   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'b1000000,   // 0
      7'b1111001,   // 1
      7'b0100100,   // 2
      7'b0110000,   // 3
      7'b0011001,   // 4
      7'b0010010,   // 5
      7'b0000010,   // 6
      7'b1111000,   // 7
      7'b0000000,   // 8
      7'b0010000,   // 9
      7'b0001000,   // A
      7'b0000011,   // b
      7'b1000110,   // C
      7'b0100001,   // d
      7'b0000110,   // E
      7'b0001110    // F
   };

   localparam logic [6:0] SEG_ZERO = 7'b1000000;

   // Counter width for a divide-by-div prescaler; never narrower than one bit
   function automatic int unsigned presc_width(input int unsigned div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scan: prescaled digit index driving registered, mutually
// aligned digit enable and segment pattern.
module seg7_scan
   import counter_display_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned SCAN_HZ    = 1000,
   parameter int unsigned NUM_DIGITS = 4
) (
   input  logic                    normalclock,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] count,
   output logic [NUM_DIGITS-1:0]   digit_select,
   output logic [6:0]              seven
);

   localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
   localparam int unsigned SCAN_W   = presc_width(SCAN_DIV);
   localparam logic [SCAN_W-1:0] SCAN_TC = SCAN_W'(SCAN_DIV - 1);
   localparam int unsigned IDX_W    = presc_width(NUM_DIGITS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [NUM_DIGITS-1:0] dsel_q, dsel_d;
   logic [6:0]            seven_q, seven_d;
   logic [3:0]            nibble;

   // Both output registers load from the next index so enable and glyph never disagree
   always_comb begin
      scan_cnt_d = scan_cnt_q + SCAN_W'(1);
      idx_d      = idx_q;
      if (scan_cnt_q == SCAN_TC) begin
         scan_cnt_d = '0;
         idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      nibble  = 4'(count >> {idx_d, 2'b00});
      dsel_d  = ~(NUM_DIGITS'(1) << idx_d);
      seven_d = GLYPH_TABLE[nibble];
   end

   always_ff @(posedge normalclock or posedge reset) begin
      if (reset) begin
         scan_cnt_q <= '0;
         idx_q      <= '0;
         dsel_q     <= ~NUM_DIGITS'(1);
         seven_q    <= SEG_ZERO;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
         dsel_q     <= dsel_d;
         seven_q    <= seven_d;
      end
   end

   assign digit_select = dsel_q;
   assign seven        = seven_q;

endmodule

// File: rtl/counter_display_core.sv
// N-digit hex/BCD up/down counter with wrap or saturate, auto-tick or button stepping,
// feeding a multiplexed 7-segment scan driver. All slow rates are clock enables.
module counter_display_core
   import counter_display_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned AUTO_HZ    = 1,
   parameter int unsigned SCAN_HZ    = 1000,
   parameter int unsigned NUM_DIGITS = 4,
   parameter bit          BCD        = 1'b0
) (
   input  logic                    normalclock,
   input  logic                    reset,
   input  logic                    inc_btn,
   input  logic                    dir,
   input  logic [1:0]              mode_select,
   input  logic                    wrap_en,
   output logic [4*NUM_DIGITS-1:0] count,
   output logic                    ovf,
   output logic [NUM_DIGITS-1:0]   digit_select,
   output logic [6:0]              seven
);

   localparam int unsigned CW       = 4 * NUM_DIGITS;
   localparam int unsigned AUTO_DIV = CLK_HZ / AUTO_HZ;
   localparam int unsigned AUTO_W   = presc_width(AUTO_DIV);
   localparam logic [AUTO_W-1:0] AUTO_TC = AUTO_W'(AUTO_DIV - 1);
   localparam logic [3:0] DIGIT_MAX = BCD ? 4'd9 : 4'd15;

   if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("counter_display_core: NUM_DIGITS must be in 1..8");
   end
   if (CLK_HZ < AUTO_HZ || CLK_HZ < SCAN_HZ) begin : g_bad_rates
      $error("counter_display_core: CLK_HZ must be >= AUTO_HZ and SCAN_HZ");
   end

   logic [AUTO_W-1:0]   auto_cnt_q, auto_cnt_d;
   logic                auto_tick;
   logic                sync1_q, sync2_q, btn_prev_q, btn_pulse_q, btn_pulse_d;
   logic [CW-1:0]       count_q, count_d, stepped;
   logic                ovf_q, ovf_d, step, limit;
   logic [NUM_DIGITS:0] chain;

   // Prescaler is parked at zero outside auto mode so entry always yields a full period
   assign auto_tick = (mode_select == MODE_AUTO) && (auto_cnt_q == AUTO_TC);

   always_comb begin
      auto_cnt_d = '0;
      if ((mode_select == MODE_AUTO) && !auto_tick)
         auto_cnt_d = auto_cnt_q + AUTO_W'(1);
   end

   assign btn_pulse_d = sync2_q & ~btn_prev_q;

   // Ripple carry/borrow: chain[gi] means every lower digit rolled over
   assign chain[0] = 1'b1;
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] cur;
      logic       at_top, at_bot;
      assign cur         = count_q[4*gi +: 4];
      assign at_top      = (cur == DIGIT_MAX);
      assign at_bot      = (cur == 4'd0);
      assign chain[gi+1] = chain[gi] & (dir ? at_bot : at_top);
      assign stepped[4*gi +: 4] = !chain[gi] ? cur :
                                  dir ? (at_bot ? DIGIT_MAX : cur - 4'd1)
                                      : (at_top ? 4'd0 : cur + 4'd1);
   end
   assign limit = chain[NUM_DIGITS];

   always_comb begin
      step    = auto_tick || ((mode_select == MODE_BTN) && btn_pulse_q);
      count_d = count_q;
      ovf_d   = 1'b0;
      if (step) begin
         ovf_d = limit;
         if (!limit || wrap_en)
            count_d = stepped;
      end
   end

   always_ff @(posedge normalclock or posedge reset) begin
      if (reset) begin
         auto_cnt_q  <= '0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         btn_prev_q  <= 1'b0;
         btn_pulse_q <= 1'b0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
      end else begin
         auto_cnt_q  <= auto_cnt_d;
         sync1_q     <= inc_btn;
         sync2_q     <= sync1_q;
         btn_prev_q  <= sync2_q;
         btn_pulse_q <= btn_pulse_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
      end
   end

   assign count = count_q;
   assign ovf   = ovf_q;

   seg7_scan #(
      .CLK_HZ     (CLK_HZ),
      .SCAN_HZ    (SCAN_HZ),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_scan (
      .normalclock  (normalclock),
      .reset        (reset),
      .count        (count_q),
      .digit_select (digit_select),
      .seven        (seven)
   );

endmodule

// File: tb/tb_counter_display_core.sv
// Bench for counter_display_core: hex and BCD instances share stimulus; every step is
// predicted into a per-instance queue and matched when the output changes or ovf pulses.
module tb_counter_display_core;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_A = 7'b0001000;

   logic       normalclock = 1'b0;
   logic       reset, inc_btn, dir, wrap_en;
   logic [1:0] mode_select;
   logic [7:0] count_hex, count_bcd;
   logic       ovf_hex, ovf_bcd;
   logic [1:0] ds_hex, ds_bcd;
   logic [6:0] seven_hex, seven_bcd;

   typedef struct { int cyc; logic [7:0] cnt; logic ovf; } exp_t;
   typedef struct { logic dir; logic wrap; int steps; logic [7:0] exp_hex; logic [7:0] exp_bcd; } vec_t;

   exp_t       q_hex[$];
   exp_t       q_bcd[$];
   vec_t       vecs[10];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         rst_cyc = 0;
   logic [7:0] m_hex, m_bcd, prev_hex, prev_bcd;

   always #5 normalclock = ~normalclock;

   counter_display_core #(.CLK_HZ(1000), .AUTO_HZ(100), .SCAN_HZ(250), .NUM_DIGITS(2), .BCD(1'b0)) dut_hex (
      .normalclock(normalclock), .reset(reset), .inc_btn(inc_btn), .dir(dir),
      .mode_select(mode_select), .wrap_en(wrap_en), .count(count_hex), .ovf(ovf_hex),
      .digit_select(ds_hex), .seven(seven_hex));

   counter_display_core #(.CLK_HZ(1000), .AUTO_HZ(100), .SCAN_HZ(250), .NUM_DIGITS(2), .BCD(1'b1)) dut_bcd (
      .normalclock(normalclock), .reset(reset), .inc_btn(inc_btn), .dir(dir),
      .mode_select(mode_select), .wrap_en(wrap_en), .count(count_bcd), .ovf(ovf_bcd),
      .digit_select(ds_bcd), .seven(seven_bcd));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference arithmetic on the decimal/integer value, independent of digit chains
   function automatic logic [8:0] model_step(input logic [7:0] c, input logic down,
                                             input logic wrap, input bit bcd);
      int   v;
      int   maxv;
      logic lim;
      v    = bcd ? (int'(c[7:4]) * 10 + int'(c[3:0])) : int'(c);
      maxv = bcd ? 99 : 255;
      lim  = down ? (v == 0) : (v == maxv);
      if (!lim) v = down ? v - 1 : v + 1;
      else if (wrap) v = down ? maxv : 0;
      if (bcd) return {lim, 4'(v / 10), 4'(v % 10)};
      return {lim, 8'(v)};
   endfunction

   task automatic predict(input int at);
      logic [8:0] r;
      exp_t       e;
      r = model_step(m_hex, dir, wrap_en, 1'b0);
      m_hex = r[7:0];
      e.cyc = at; e.cnt = r[7:0]; e.ovf = r[8];
      q_hex.push_back(e);
      r = model_step(m_bcd, dir, wrap_en, 1'b1);
      m_bcd = r[7:0];
      e.cyc = at; e.cnt = r[7:0]; e.ovf = r[8];
      q_bcd.push_back(e);
   endtask

   task automatic monitor();
      exp_t e;
      if (reset) begin
         prev_hex = 8'h00;
         prev_bcd = 8'h00;
         return;
      end
      if (count_hex != prev_hex || ovf_hex) begin
         if (q_hex.size() == 0) begin
            check("hex unexpected step", 32'({ovf_hex, count_hex}), 32'({1'b0, prev_hex}));
         end else begin
            e = q_hex.pop_front();
            $display("hex step cyc=%0d count=%02h ovf=%0b", cyc, count_hex, ovf_hex);
            check("hex step cycle", 32'(cyc), 32'(e.cyc));
            check("hex step count", 32'(count_hex), 32'(e.cnt));
            check("hex step ovf", 32'(ovf_hex), 32'(e.ovf));
         end
         prev_hex = count_hex;
      end
      if (count_bcd != prev_bcd || ovf_bcd) begin
         if (q_bcd.size() == 0) begin
            check("bcd unexpected step", 32'({ovf_bcd, count_bcd}), 32'({1'b0, prev_bcd}));
         end else begin
            e = q_bcd.pop_front();
            $display("bcd step cyc=%0d count=%02h ovf=%0b", cyc, count_bcd, ovf_bcd);
            check("bcd step cycle", 32'(cyc), 32'(e.cyc));
            check("bcd step count", 32'(count_bcd), 32'(e.cnt));
            check("bcd step ovf", 32'(ovf_bcd), 32'(e.ovf));
         end
         prev_bcd = count_bcd;
      end
   endtask

   task automatic cycle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge normalclock);
         cyc++;
         #1;
         monitor();
      end
   endtask

   // Enter auto mode now; n ticks expected exactly 10, 20, ... cycles later, then pause
   task automatic auto_run(input int n, input bit press);
      int start;
      start = cyc;
      mode_select = 2'b00;
      for (int k = 1; k <= n; k++) predict(start + 10 * k);
      if (press) begin
         cycle(2);
         inc_btn = 1'b1;
         cycle(4);
         inc_btn = 1'b0;
      end
      cycle(start + 10 * n - cyc);
      mode_select = 2'b10;
   endtask

   task automatic press_btn(input int hold);
      int start;
      start = cyc;
      inc_btn = 1'b1;
      if (mode_select == 2'b01) predict(start + 4);
      cycle(hold);
      inc_btn = 1'b0;
      cycle(6);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " count_hex"}, 32'(count_hex), 32'h0);
      check({tag, " count_bcd"}, 32'(count_bcd), 32'h0);
      check({tag, " ovf"}, 32'({ovf_hex, ovf_bcd}), 32'h0);
      check({tag, " digit_select"}, 32'(ds_hex), 32'h2);
      check({tag, " seven"}, 32'(seven_hex), 32'(SEG_0));
   endtask

   initial begin
      int         k;
      int         start;
      logic [1:0] exp_ds;

      reset = 1'b1; inc_btn = 1'b0; dir = 1'b0; wrap_en = 1'b1; mode_select = 2'b10;
      m_hex = 8'h00; m_bcd = 8'h00; prev_hex = 8'h00; prev_bcd = 8'h00;

      vecs[0] = '{1'b0, 1'b1, 255, 8'hFF, 8'h55};
      vecs[1] = '{1'b0, 1'b1,   1, 8'h00, 8'h56};
      vecs[2] = '{1'b1, 1'b0,  46, 8'h00, 8'h10};
      vecs[3] = '{1'b1, 1'b0,   1, 8'h00, 8'h09};
      vecs[4] = '{1'b1, 1'b0,   9, 8'h00, 8'h00};
      vecs[5] = '{1'b1, 1'b0,   1, 8'h00, 8'h00};
      vecs[6] = '{1'b1, 1'b1,   1, 8'hFF, 8'h99};
      vecs[7] = '{1'b0, 1'b0,   1, 8'hFF, 8'h99};
      vecs[8] = '{1'b1, 1'b1,   3, 8'hFC, 8'h96};
      vecs[9] = '{1'b0, 1'b1,  62, 8'h3A, 8'h58};

      cycle(3);
      check_reset_outputs("initial reset");
      reset = 1'b0;
      rst_cyc = cyc;

      for (int i = 0; i < 10; i++) begin
         dir = vecs[i].dir;
         wrap_en = vecs[i].wrap;
         auto_run(vecs[i].steps, 1'b0);
         $display("vector %0d: dir=%0b wrap=%0b steps=%0d -> hex %02h bcd %02h",
                  i, vecs[i].dir, vecs[i].wrap, vecs[i].steps, count_hex, count_bcd);
         check($sformatf("vec%0d hex", i), 32'(count_hex), 32'(vecs[i].exp_hex));
         check($sformatf("vec%0d bcd", i), 32'(count_bcd), 32'(vecs[i].exp_bcd));
      end

      // Scan of 0x3A: index position derived from cycles since reset release
      for (int i = 0; i < 16; i++) begin
         cycle(1);
         k = cyc - rst_cyc;
         exp_ds = (((k / 4) % 2) == 0) ? 2'b10 : 2'b01;
         $display("scan cyc=%0d digit_select=%b seven=%b", cyc, ds_hex, seven_hex);
         check("scan digit_select", 32'(ds_hex), 32'(exp_ds));
         check("scan seven", 32'(seven_hex), 32'((exp_ds == 2'b10) ? SEG_A : SEG_3));
      end

      // Button: one step per press in mode 01 only
      dir = 1'b0; wrap_en = 1'b1;
      mode_select = 2'b01;
      press_btn(50);
      check("btn hex", 32'(count_hex), 32'h3B);
      check("btn bcd", 32'(count_bcd), 32'h59);
      auto_run(2, 1'b1);
      check("btn-in-auto hex", 32'(count_hex), 32'h3D);
      check("btn-in-auto bcd", 32'(count_bcd), 32'h61);
      mode_select = 2'b10;
      press_btn(20);
      mode_select = 2'b01;
      cycle(10);
      mode_select = 2'b10;
      check("btn-in-pause hex", 32'(count_hex), 32'h3D);

      // Pause then resume: first tick a full prescale period after re-entry
      cycle(100);
      check("pause hex", 32'(count_hex), 32'h3D);
      check("pause bcd", 32'(count_bcd), 32'h61);
      check("pause ovf", 32'({ovf_hex, ovf_bcd}), 32'h0);
      auto_run(1, 1'b0);
      check("resume hex", 32'(count_hex), 32'h3E);
      check("resume bcd", 32'(count_bcd), 32'h62);

      // Reset mid-count and mid-prescale
      start = cyc;
      mode_select = 2'b00;
      for (int j = 1; j <= 25; j++) predict(start + 10 * j);
      cycle(255);
      check("pre-reset hex", 32'(count_hex), 32'h57);
      check("pre-reset bcd", 32'(count_bcd), 32'h87);
      #2 reset = 1'b1;
      #1;
      check_reset_outputs("async reset");
      check("queue drained before reset", 32'(q_hex.size() + q_bcd.size()), 32'h0);
      m_hex = 8'h00; m_bcd = 8'h00;
      cycle(3);
      reset = 1'b0;
      rst_cyc = cyc;
      predict(cyc + 10);
      predict(cyc + 20);
      cycle(20);
      mode_select = 2'b10;
      check("post-reset hex", 32'(count_hex), 32'h02);
      check("post-reset bcd", 32'(count_bcd), 32'h02);

      // Button held through reset release gives exactly one step
      mode_select = 2'b01;
      inc_btn = 1'b1;
      reset = 1'b1;
      cycle(3);
      m_hex = 8'h00; m_bcd = 8'h00;
      reset = 1'b0;
      predict(cyc + 4);
      cycle(20);
      inc_btn = 1'b0;
      cycle(6);
      mode_select = 2'b10;
      check("held-through-reset hex", 32'(count_hex), 32'h01);
      check("held-through-reset bcd", 32'(count_bcd), 32'h01);

      check("hex queue empty", 32'(q_hex.size()), 32'h0);
      check("bcd queue empty", 32'(q_bcd.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
